// File: rtl/lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen
//
// Parametrised linear-feedback shift register generator with run-time
// Fibonacci/Galois selection, synchronous load, all-zero lockup recovery and
// period measurement.
//
// Parameters
//   WIDTH  state width in bits (3..32)
//   TAPS   Fibonacci tap mask; feedback is the XOR of the masked state bits
//   GPOLY  Galois polynomial without the x^WIDTH term (bit 0 must be 1)
//   SEED   reset, lockup-recovery and wrap-reference value (non-zero)
//
// Ports
//   CLK       clock, rising edge
//   RESET     asynchronous active-low reset
//   EN        advance the LFSR one step this cycle
//   LOAD      synchronous load of LOAD_VAL (wins over EN)
//   LOAD_VAL  value written by LOAD
//   GALOIS    0 = Fibonacci step, 1 = Galois step (sampled on every step)
//   O         current LFSR state
//   WRAP      one-cycle pulse when the state has just returned to SEED
//   LOCKUP    one-cycle pulse when recovery from the all-zero state occurred
//   COUNT     steps since the last load, wrap or lockup
//   PERIOD    last measured period, latched together with WRAP
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module lfsr_gen #(
   parameter int unsigned WIDTH = 8,
   parameter logic [31:0] TAPS  = 32'h0000_00B8,
   parameter logic [31:0] GPOLY = 32'h0000_001D,
   parameter logic [31:0] SEED  = 32'h0000_0001
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   input  logic             GALOIS,
   output logic [WIDTH-1:0] O,
   output logic             WRAP,
   output logic             LOCKUP,
   output logic [WIDTH-1:0] COUNT,
   output logic [WIDTH-1:0] PERIOD
);

   // Parameters are declared 32 bits wide so the defaults fit any WIDTH;
   // only the low WIDTH bits are meaningful.
   localparam logic [WIDTH-1:0] TAPS_W  = TAPS[WIDTH-1:0];
   localparam logic [WIDTH-1:0] GPOLY_W = GPOLY[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED_W  = SEED[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

   // Even-parity helper: XOR reduction of a WIDTH-bit vector.
   function automatic logic parity_of(input logic [WIDTH-1:0] vec);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         acc = acc ^ vec[i];
      end
      return acc;
   endfunction

   // Fibonacci step: shift left, newest bit enters at bit 0.
   function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] cur);
      return {cur[WIDTH-2:0], parity_of(cur & TAPS_W)};
   endfunction

   // Galois step: shift left, fold the polynomial in when the MSB falls out.
   function automatic logic [WIDTH-1:0] gal_step(input logic [WIDTH-1:0] cur);
      return {cur[WIDTH-2:0], 1'b0} ^ ({WIDTH{cur[WIDTH-1]}} & GPOLY_W);
   endfunction

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] period_r;
   logic             wrap_r;
   logic             lockup_r;

   logic [WIDTH-1:0] step_s;
   logic [WIDTH-1:0] state_nxt_s;
   logic [WIDTH-1:0] count_nxt_s;
   logic [WIDTH-1:0] period_nxt_s;
   logic             wrap_nxt_s;
   logic             lockup_nxt_s;

   // Candidate next state for a normal step under the currently selected mode.
   always_comb begin
      step_s = state_r;
      if (GALOIS) begin
         step_s = gal_step(state_r);
      end else begin
         step_s = fib_step(state_r);
      end
   end

   // Next-state selection: LOAD, then step, then hold.
   always_comb begin
      state_nxt_s  = state_r;
      count_nxt_s  = count_r;
      period_nxt_s = period_r;
      wrap_nxt_s   = 1'b0;
      lockup_nxt_s = 1'b0;
      if (LOAD) begin
         state_nxt_s = LOAD_VAL;
         count_nxt_s = ZERO_W;
      end else if (EN) begin
         if (state_r == ZERO_W) begin
            // All-zero is a fixed point of both rules; recover to SEED.
            state_nxt_s  = SEED_W;
            count_nxt_s  = ZERO_W;
            lockup_nxt_s = 1'b1;
         end else if (step_s == SEED_W) begin
            // Returned to the reference value: this step closes one period.
            state_nxt_s  = step_s;
            count_nxt_s  = ZERO_W;
            period_nxt_s = count_r + ONE_W;
            wrap_nxt_s   = 1'b1;
         end else begin
            state_nxt_s = step_s;
            count_nxt_s = count_r + ONE_W;
         end
      end else begin
         state_nxt_s = state_r;
         count_nxt_s = count_r;
      end
   end

   // State, counters and pulse registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r  <= SEED_W;
         count_r  <= ZERO_W;
         period_r <= ZERO_W;
         wrap_r   <= 1'b0;
         lockup_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         count_r  <= count_nxt_s;
         period_r <= period_nxt_s;
         wrap_r   <= wrap_nxt_s;
         lockup_r <= lockup_nxt_s;
      end
   end

   assign O      = state_r;
   assign COUNT  = count_r;
   assign PERIOD = period_r;
   assign WRAP   = wrap_r;
   assign LOCKUP = lockup_r;

endmodule
